// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - handshake bundle between the shifter and its producer/consumer
// master drives operations and consumes results; slave is the shifter side.
interface pipelined_barrel_shifter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int SHAMT_W = $clog2(XLEN);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined SLL/SRL/SRA(/ROR) barrel shifter with valid/ready and flush
// Optional rotate: define SHIFTER_ROTATE_EN to build ROR for op 2'b11; otherwise op 2'b11 acts as SRL.
// Shift stages by 2^k are spread over PIPE_DEPTH register groups; the last register drives the outputs.
module pipelined_barrel_shifter #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int GRP_C   = (SHAMT_W + PIPE_DEPTH - 1) / PIPE_DEPTH;
  localparam int LAST    = PIPE_DEPTH - 1;
  localparam logic [XLEN-1:0] ONES = '1;

  // Applies the shift stages k in [lo, hi) selected by the shamt bits.
  function automatic logic [XLEN-1:0] shift_group(
    input logic [XLEN-1:0]    din,
    input logic [SHAMT_W-1:0] shamt,
    input logic [1:0]         op,
    input logic               sign,
    input int                 lo,
    input int                 hi
  );
    logic [XLEN-1:0] d;
    d = din;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (k >= lo && k < hi && shamt[k]) begin
        case (op)
          2'b00:   d = d << (1 << k);
          2'b10:   d = (d >> (1 << k)) | ({XLEN{sign}} & ~(ONES >> (1 << k)));
`ifdef SHIFTER_ROTATE_EN
          2'b11:   d = (d >> (1 << k)) | (d << (XLEN - (1 << k)));
`endif
          default: d = d >> (1 << k);
        endcase
      end
    end
    return d;
  endfunction

  // Inputs seen by each shift group (group 0 from the bus, others from the previous register).
  logic [XLEN-1:0]    grp_data  [PIPE_DEPTH];
  logic [SHAMT_W-1:0] grp_shamt [PIPE_DEPTH];
  logic [1:0]         grp_op    [PIPE_DEPTH];
  logic               grp_sign  [PIPE_DEPTH];
  logic [TAG_W-1:0]   grp_tag   [PIPE_DEPTH];
  logic               grp_valid [PIPE_DEPTH];

  // Pipeline register outputs and per-stage advance permission.
  logic [XLEN-1:0]    stg_data  [PIPE_DEPTH];
  logic [TAG_W-1:0]   stg_tag   [PIPE_DEPTH];
  logic               stg_valid [PIPE_DEPTH];
  logic               stg_ready [PIPE_DEPTH];

  // A stage may load when it or any stage downstream of it is empty, or the consumer takes the result.
  always_comb begin
    logic r;
    r = bus.out_ready;
    for (int g = LAST; g >= 0; g--) begin
      r            = r | ~stg_valid[g];
      stg_ready[g] = r;
    end
  end

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
    localparam int LO = g * GRP_C;
    localparam int HI = ((g + 1) * GRP_C < SHAMT_W) ? (g + 1) * GRP_C : SHAMT_W;

    logic              valid_q;
    logic              valid_d;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   data_d;
    logic [TAG_W-1:0]  tag_q;
    logic              load;

    if (g == 0) begin : g_src
      // A flush cycle never accepts the offered operation.
      assign grp_valid[g] = bus.in_valid & ~bus.flush;
      assign grp_data[g]  = bus.in_data;
      assign grp_shamt[g] = bus.in_shamt;
      assign grp_op[g]    = bus.in_op;
      assign grp_sign[g]  = bus.in_data[XLEN-1];
      assign grp_tag[g]   = bus.in_tag;
    end else begin : g_src
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         op_q;
      logic               sign_q;

      // Side-band fields travel with pipeline register g-1 and load with it.
      always_ff @(posedge clk) begin
        if (stg_ready[g-1] && grp_valid[g-1]) begin
          shamt_q <= grp_shamt[g-1];
          op_q    <= grp_op[g-1];
          sign_q  <= grp_sign[g-1];
        end
      end

      assign grp_valid[g] = stg_valid[g-1];
      assign grp_data[g]  = stg_data[g-1];
      assign grp_shamt[g] = shamt_q;
      assign grp_op[g]    = op_q;
      assign grp_sign[g]  = sign_q;
      assign grp_tag[g]   = stg_tag[g-1];
    end

    assign load    = stg_ready[g] & grp_valid[g];
    assign valid_d = bus.flush ? 1'b0 : (stg_ready[g] ? grp_valid[g] : valid_q);
    assign data_d  = shift_group(grp_data[g], grp_shamt[g], grp_op[g], grp_sign[g], LO, HI);

    // Valid bit: cleared by reset or flush, otherwise follows upstream whenever the stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    if (g == LAST) begin : g_reg
      // Output register is reset so out_data/out_tag read zero after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          tag_q  <= '0;
        end else if (load) begin
          data_q <= data_d;
          tag_q  <= grp_tag[g];
        end
      end
    end else begin : g_reg
      // Interior data registers need no reset; their valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (load) begin
          data_q <= data_d;
          tag_q  <= grp_tag[g];
        end
      end
    end

    assign stg_valid[g] = valid_q;
    assign stg_data[g]  = data_q;
    assign stg_tag[g]   = tag_q;
  end

  assign bus.in_ready  = stg_ready[0] & ~bus.flush;
  assign bus.out_valid = stg_valid[LAST];
  assign bus.out_data  = stg_data[LAST];
  assign bus.out_tag   = stg_tag[LAST];

endmodule
